// File: rtl/gemac_rx_pkg.sv
// Shared types and constants for the GEMAC receive front end.
package gemac_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StBody,
    StDiscard
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned LEN_W         = 12;

endpackage

// File: rtl/gemac_rx_sfd_align.sv
// GMII receive front end: strips preamble/SFD and delivers the frame body with
// sof/eof/err framing, using a one-byte hold register so eof lands on the last byte.
module gemac_rx_sfd_align
  import gemac_rx_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 2,
  parameter int unsigned MIN_LEN      = 64,
  parameter int unsigned MAX_LEN      = 1522
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [7:0] gmii_rxd,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_err
);

  rx_state_e        state_q, state_d;
  logic [3:0]       pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             first_q, first_d;
  logic             sticky_err_q, sticky_err_d;

  logic [7:0]       data_d;
  logic             valid_d, sof_d, eof_d, err_d;

  logic [31:0]      len_ext;
  assign len_ext = 32'(len_q);

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    len_d        = len_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    first_d      = first_q;
    sticky_err_d = sticky_err_q;
    data_d       = 8'h00;
    valid_d      = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gmii_rx_dv) begin
          if (gmii_rx_er) begin
            state_d = StDiscard;
          end else if (gmii_rxd == PREAMBLE_BYTE) begin
            state_d   = StPreamble;
            pre_cnt_d = 4'd1;
          end else if (gmii_rxd == SFD_BYTE && MIN_PREAMBLE == 0) begin
            state_d      = StBody;
            len_d        = '0;
            hold_full_d  = 1'b0;
            first_d      = 1'b1;
            sticky_err_d = 1'b0;
          end else begin
            state_d = StDiscard;
          end
        end
      end

      StPreamble: begin
        if (!gmii_rx_dv) begin
          state_d = StIdle;
        end else if (gmii_rx_er) begin
          state_d = StDiscard;
        end else if (gmii_rxd == PREAMBLE_BYTE) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (gmii_rxd == SFD_BYTE && 32'(pre_cnt_q) >= MIN_PREAMBLE) begin
          state_d      = StBody;
          len_d        = '0;
          hold_full_d  = 1'b0;
          first_d      = 1'b1;
          sticky_err_d = 1'b0;
        end else begin
          state_d = StDiscard;
        end
      end

      StBody: begin
        if (gmii_rx_dv) begin
          if (len_ext >= MAX_LEN) begin
            // Overlength: drop the new byte and close the frame on the held one.
            valid_d     = hold_full_q;
            data_d      = hold_q;
            sof_d       = hold_full_q & first_q;
            eof_d       = hold_full_q;
            err_d       = hold_full_q;
            hold_full_d = 1'b0;
            first_d     = 1'b0;
            state_d     = StDiscard;
          end else begin
            hold_d       = gmii_rxd;
            hold_full_d  = 1'b1;
            sticky_err_d = sticky_err_q | gmii_rx_er;
            if (len_q != '1) len_d = len_q + LEN_W'(1);
            if (hold_full_q) begin
              valid_d = 1'b1;
              data_d  = hold_q;
              sof_d   = first_q;
              first_d = 1'b0;
            end
          end
        end else begin
          // An SFD with no body leaves the hold empty, so nothing is emitted.
          valid_d     = hold_full_q;
          data_d      = hold_full_q ? hold_q : 8'h00;
          sof_d       = hold_full_q & first_q;
          eof_d       = hold_full_q;
          err_d       = hold_full_q & (sticky_err_q | (len_ext < MIN_LEN));
          hold_full_d = 1'b0;
          first_d     = 1'b0;
          state_d     = StIdle;
        end
      end

      StDiscard: begin
        if (!gmii_rx_dv) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pre_cnt_q    <= 4'd0;
      len_q        <= '0;
      hold_q       <= 8'h00;
      hold_full_q  <= 1'b0;
      first_q      <= 1'b0;
      sticky_err_q <= 1'b0;
      out_data     <= 8'h00;
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      len_q        <= len_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      first_q      <= first_d;
      sticky_err_q <= sticky_err_d;
      out_data     <= data_d;
      out_valid    <= valid_d;
      out_sof      <= sof_d;
      out_eof      <= eof_d;
      out_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_gemac_rx_sfd_align.sv
// Randomized bench: two instances (default and MAX_LEN=100) share GMII stimulus and
// are scored against a frame-level model of expected body beats and their cycles.
module tb_gemac_rx_sfd_align;

  localparam int MIN_PRE = 2;
  localparam int MIN_LEN = 64;

  typedef logic [7:0] byte_q_t[$];
  typedef bit bit_q_t[$];
  typedef int int_q_t[$];
  typedef struct packed {
    logic [11:0] v;  // {valid, sof, eof, err, data}
    int          cyc;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dv = 1'b0;
  logic       er = 1'b0;
  logic [7:0] rxd = 8'h00;

  logic [7:0] a_data, b_data;
  logic       a_valid, a_sof, a_eof, a_err;
  logic       b_valid, b_sof, b_eof, b_err;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  beat_t obs[2][$];
  beat_t expq[2][$];

  gemac_rx_sfd_align dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .gmii_rx_dv(dv),
    .gmii_rx_er(er),
    .gmii_rxd  (rxd),
    .out_data  (a_data),
    .out_valid (a_valid),
    .out_sof   (a_sof),
    .out_eof   (a_eof),
    .out_err   (a_err)
  );

  gemac_rx_sfd_align #(.MAX_LEN(100)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .gmii_rx_dv(dv),
    .gmii_rx_er(er),
    .gmii_rxd  (rxd),
    .out_data  (b_data),
    .out_valid (b_valid),
    .out_sof   (b_sof),
    .out_eof   (b_eof),
    .out_err   (b_err)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Any asserted output is recorded, so stray sof/eof/err without valid also shows up.
  always @(negedge clk) begin
    if (a_valid | a_sof | a_eof | a_err) obs[0].push_back({a_valid, a_sof, a_eof, a_err, a_data, cyc});
    if (b_valid | b_sof | b_eof | b_err) obs[1].push_back({b_valid, b_sof, b_eof, b_err, b_data, cyc});
  end

  // Frame-level reference: every accepted body byte appears two cycles after it was presented.
  function automatic void model(input byte_q_t b, input bit_q_t e, input int_q_t c,
                                input int max_len, output beat_t r[$]);
    int    n, blen, nout;
    bit    bad;
    beat_t bt;
    r.delete();
    n = 0;
    while (n < b.size() && b[n] == 8'h55 && !e[n]) n++;
    if (n >= b.size()) return;
    if (b[n] != 8'hD5 || e[n] || ((n > 15) ? 15 : n) < MIN_PRE) return;
    blen = b.size() - n - 1;
    if (blen == 0) return;
    nout = (blen > max_len) ? max_len : blen;
    bad  = (blen > max_len) || (blen < MIN_LEN);
    for (int i = 0; i < nout; i++) bad |= e[n+1+i];
    for (int i = 0; i < nout; i++) begin
      bt.v   = {1'b1, i == 0, i == nout - 1, (i == nout - 1) && bad, b[n+1+i]};
      bt.cyc = c[n+1+i] + 2;
      r.push_back(bt);
    end
  endfunction

  function automatic void build(input int npre, input int blen, input bit incr,
                                output byte_q_t b, output bit_q_t e);
    b.delete();
    e.delete();
    for (int i = 0; i < npre; i++) begin b.push_back(8'h55); e.push_back(1'b0); end
    b.push_back(8'hD5);
    e.push_back(1'b0);
    for (int i = 0; i < blen; i++) begin
      b.push_back(incr ? 8'(i) : 8'($urandom));
      e.push_back(1'b0);
    end
  endfunction

  task automatic drive_burst(input byte_q_t b, input bit_q_t e, input int gap);
    int_q_t c;
    beat_t  r[$];
    for (int i = 0; i < b.size(); i++) begin
      @(posedge clk); #1;
      dv  = 1'b1;
      rxd = b[i];
      er  = e[i];
      c.push_back(cyc);
    end
    @(posedge clk); #1;
    dv  = 1'b0;
    er  = 1'b0;
    rxd = 8'($urandom);
    for (int i = 1; i < gap; i++) @(posedge clk);
    model(b, e, c, 1522, r);
    foreach (r[i]) expq[0].push_back(r[i]);
    model(b, e, c, 100, r);
    foreach (r[i]) expq[1].push_back(r[i]);
  endtask

  task automatic clear_scores();
    for (int d = 0; d < 2; d++) begin
      obs[d].delete();
      expq[d].delete();
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_valid, a_sof, a_eof, a_err, a_data} !== 12'h0) begin
      errors++;
      $display("FAIL reset_a got %h want 000", {a_valid, a_sof, a_eof, a_err, a_data});
    end
    checks++;
    if ({b_valid, b_sof, b_eof, b_err, b_data} !== 12'h0) begin
      errors++;
      $display("FAIL reset_b got %h want 000", {b_valid, b_sof, b_eof, b_err, b_data});
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_scores();
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs[0].size() + obs[1].size() !== 0) begin
      errors++;
      $display("FAIL reset_idle beats got %0d want 0", obs[0].size() + obs[1].size());
    end
  endtask

  task automatic test_basic();
    byte_q_t b;
    bit_q_t  e;
    clear_scores();
    build(7, 64, 1'b1, b, e);
    drive_burst(b, e, 3);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d].size() !== expq[d].size()) begin
        errors++;
        $display("FAIL basic[%0d] beats got %0d want %0d", d, obs[d].size(), expq[d].size());
      end
      for (int i = 0; i < obs[d].size() && i < expq[d].size(); i++) begin
        checks++;
        if (obs[d][i] !== expq[d][i]) begin
          errors++;
          $display("FAIL basic[%0d] beat %0d got %h@%0d want %h@%0d", d, i, obs[d][i].v,
                   obs[d][i].cyc, expq[d][i].v, expq[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_short_preamble();
    byte_q_t b;
    bit_q_t  e;
    clear_scores();
    build(1, 20, 1'b0, b, e);
    drive_burst(b, e, 2);
    build(3, 70, 1'b0, b, e);
    drive_burst(b, e, 3);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d].size() !== expq[d].size()) begin
        errors++;
        $display("FAIL short_pre[%0d] beats got %0d want %0d", d, obs[d].size(), expq[d].size());
      end
      for (int i = 0; i < obs[d].size() && i < expq[d].size(); i++) begin
        checks++;
        if (obs[d][i] !== expq[d][i]) begin
          errors++;
          $display("FAIL short_pre[%0d] beat %0d got %h@%0d want %h@%0d", d, i, obs[d][i].v,
                   obs[d][i].cyc, expq[d][i].v, expq[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_rx_er();
    byte_q_t b;
    bit_q_t  e;
    clear_scores();
    build(2, 100, 1'b0, b, e);
    e[3+10] = 1'b1;
    drive_burst(b, e, 3);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d].size() !== expq[d].size()) begin
        errors++;
        $display("FAIL rx_er[%0d] beats got %0d want %0d", d, obs[d].size(), expq[d].size());
      end
      for (int i = 0; i < obs[d].size() && i < expq[d].size(); i++) begin
        checks++;
        if (obs[d][i] !== expq[d][i]) begin
          errors++;
          $display("FAIL rx_er[%0d] beat %0d got %h@%0d want %h@%0d", d, i, obs[d][i].v,
                   obs[d][i].cyc, expq[d][i].v, expq[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_runt();
    byte_q_t b;
    bit_q_t  e;
    clear_scores();
    build(4, 20, 1'b0, b, e);
    drive_burst(b, e, 1);
    build(2, 0, 1'b0, b, e);
    drive_burst(b, e, 1);
    build(2, 1, 1'b0, b, e);
    drive_burst(b, e, 1);
    build(2, 64, 1'b1, b, e);
    drive_burst(b, e, 2);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d].size() !== expq[d].size()) begin
        errors++;
        $display("FAIL runt[%0d] beats got %0d want %0d", d, obs[d].size(), expq[d].size());
      end
      for (int i = 0; i < obs[d].size() && i < expq[d].size(); i++) begin
        checks++;
        if (obs[d][i] !== expq[d][i]) begin
          errors++;
          $display("FAIL runt[%0d] beat %0d got %h@%0d want %h@%0d", d, i, obs[d][i].v,
                   obs[d][i].cyc, expq[d][i].v, expq[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_overlength();
    byte_q_t b;
    bit_q_t  e;
    clear_scores();
    build(5, 150, 1'b0, b, e);
    drive_burst(b, e, 1);
    build(2, 80, 1'b0, b, e);
    drive_burst(b, e, 1);
    build(2, 101, 1'b1, b, e);
    drive_burst(b, e, 1);
    build(2, 100, 1'b1, b, e);
    drive_burst(b, e, 2);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d].size() !== expq[d].size()) begin
        errors++;
        $display("FAIL overlen[%0d] beats got %0d want %0d", d, obs[d].size(), expq[d].size());
      end
      for (int i = 0; i < obs[d].size() && i < expq[d].size(); i++) begin
        checks++;
        if (obs[d][i] !== expq[d][i]) begin
          errors++;
          $display("FAIL overlen[%0d] beat %0d got %h@%0d want %h@%0d", d, i, obs[d][i].v,
                   obs[d][i].cyc, expq[d][i].v, expq[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t b;
    bit_q_t  e;
    int      npre, blen, sel;
    clear_scores();
    for (int f = 0; f < 24; f++) begin
      npre = $urandom_range(0, 17);
      sel  = $urandom_range(0, 9);
      blen = (sel == 0) ? 0 : (sel == 1) ? 1 : $urandom_range(2, 130);
      build(npre, blen, 1'b0, b, e);
      if ($urandom_range(0, 9) == 0) b[$urandom_range(0, npre)] = 8'($urandom);
      if ($urandom_range(0, 19) == 0) e[$urandom_range(0, npre)] = 1'b1;
      if (blen > 0 && $urandom_range(0, 3) == 0) e[npre + 1 + $urandom_range(0, blen - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) void'(b.pop_back());
      drive_burst(b, e, $urandom_range(1, 3));
    end
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d].size() !== expq[d].size()) begin
        errors++;
        $display("FAIL b2b[%0d] beats got %0d want %0d", d, obs[d].size(), expq[d].size());
      end
      for (int i = 0; i < obs[d].size() && i < expq[d].size(); i++) begin
        checks++;
        if (obs[d][i] !== expq[d][i]) begin
          errors++;
          $display("FAIL b2b[%0d] beat %0d got %h@%0d want %h@%0d", d, i, obs[d][i].v,
                   obs[d][i].cyc, expq[d][i].v, expq[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    byte_q_t b;
    bit_q_t  e;
    beat_t   bt;
    clear_scores();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dv  = 1'b1;
      er  = 1'b0;
      rxd = (i == 3) ? 8'hD5 : 8'h55;
    end
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      rxd = 8'(k);
      // Beats still in flight when reset hits (bytes 28, 29) are lost.
      if (k < 28) begin
        bt.v   = {1'b1, k == 0, 2'b00, 8'(k)};
        bt.cyc = cyc + 2;
        expq[0].push_back(bt);
        expq[1].push_back(bt);
      end
      if (k == 30) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_sof, a_eof, a_err, a_data, b_valid, b_sof, b_eof, b_err, b_data} !== 24'h0) begin
          errors++;
          $display("FAIL mid_reset outputs got %h/%h want 000/000",
                   {a_valid, a_sof, a_eof, a_err, a_data}, {b_valid, b_sof, b_eof, b_err, b_data});
        end
      end
      if (k == 31) reset_n = 1'b1;
    end
    @(posedge clk); #1;
    dv = 1'b0;
    build(2, 70, 1'b0, b, e);
    drive_burst(b, e, 2);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d].size() !== expq[d].size()) begin
        errors++;
        $display("FAIL mid_reset[%0d] beats got %0d want %0d", d, obs[d].size(), expq[d].size());
      end
      for (int i = 0; i < obs[d].size() && i < expq[d].size(); i++) begin
        checks++;
        if (obs[d][i] !== expq[d][i]) begin
          errors++;
          $display("FAIL mid_reset[%0d] beat %0d got %h@%0d want %h@%0d", d, i, obs[d][i].v,
                   obs[d][i].cyc, expq[d][i].v, expq[d][i].cyc);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_short_preamble();
    test_rx_er();
    test_runt();
    test_overlength();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
